// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared constants and state encoding for the iterative binary-to-BCD converter.
package bin_to_bcd_seq_pkg;

  localparam int         BCD_DIGIT_W = 4;
  localparam logic [3:0] ADD3_THRESH = 4'd5;
  localparam logic [3:0] ADD3_VAL    = 4'd3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/bin_to_bcd_seq_bcd_add3.sv
// Per-digit correction applied before each shift: digits of 5 or more get +3
// so that the following shift carries cleanly into the next decade.
module bcd_add3
  import bin_to_bcd_seq_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] d,
  output logic [BCD_DIGIT_W-1:0] q
);

  assign q = (d >= ADD3_THRESH) ? d + ADD3_VAL : d;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Shift-and-add-3 converter: one bit per clock, BIN_W clocks per conversion,
// result and overflow held until the next completed conversion.
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int BIN_W  = 10,
  parameter int DIGITS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [BIN_W-1:0]              bin_in,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
  output logic                          overflow
);

  localparam int WORK_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W  = $clog2(BIN_W + 1);

  state_t             state;
  logic [BIN_W-1:0]   bin_reg;
  logic [WORK_W-1:0]  work;
  logic [WORK_W-1:0]  work_adj;
  logic [WORK_W-1:0]  work_next;
  logic               carry_out;
  logic               ovf_sticky;
  logic [CNT_W-1:0]   cnt;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_add3 u_add3 (
      .d (work[BCD_DIGIT_W*i +: BCD_DIGIT_W]),
      .q (work_adj[BCD_DIGIT_W*i +: BCD_DIGIT_W])
    );
  end

  // Bits pushed out of the top digit are dropped; the sticky bit records them.
  assign {carry_out, work_next} = {work_adj, bin_reg[BIN_W-1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      bcd_out    <= '0;
      overflow   <= 1'b0;
      cnt        <= '0;
      bin_reg    <= '0;
      work       <= '0;
      ovf_sticky <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            bin_reg    <= bin_in;
            work       <= '0;
            ovf_sticky <= 1'b0;
            cnt        <= CNT_W'(BIN_W);
            busy       <= 1'b1;
            state      <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          work       <= work_next;
          bin_reg    <= bin_reg << 1;
          ovf_sticky <= ovf_sticky | carry_out;
          cnt        <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            bcd_out  <= work_next;
            overflow <= ovf_sticky | carry_out;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: default instance plus a 14-bit-input instance for overflow cases.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start_a = 1'b0;
  logic [9:0]  bin_a = '0;
  logic        busy_a, done_a, ovf_a;
  logic [15:0] bcd_a;

  logic        start_b = 1'b0;
  logic [13:0] bin_b = '0;
  logic        busy_b, done_b, ovf_b;
  logic [15:0] bcd_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.BIN_W(10), .DIGITS(4)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .bin_in(bin_a),
    .busy(busy_a), .done(done_a), .bcd_out(bcd_a), .overflow(ovf_a)
  );

  bin_to_bcd_seq #(.BIN_W(14), .DIGITS(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .bin_in(bin_b),
    .busy(busy_b), .done(done_b), .bcd_out(bcd_b), .overflow(ovf_b)
  );

  // Reference: decimal digits of v mod 10**4, built with plain arithmetic.
  function automatic logic [15:0] ref_bcd(input int v);
    logic [15:0] r;
    int m;
    r = '0;
    m = v % 10000;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  // Pulse start for one edge, then wait (bounded) for done. lat counts edges after acceptance.
  task automatic run_a(input logic [9:0] v, output logic [15:0] r, output logic o,
                       output int lat, output int busy_cycles);
    @(negedge clk);
    start_a = 1'b1;
    bin_a   = v;
    @(posedge clk);
    #1 start_a = 1'b0;
    lat = 0;
    busy_cycles = busy_a ? 1 : 0;
    while (!done_a && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy_a) busy_cycles++;
    end
    r = bcd_a;
    o = ovf_a;
  endtask

  task automatic run_b(input logic [13:0] v, output logic [15:0] r, output logic o,
                       output int lat);
    @(negedge clk);
    start_b = 1'b1;
    bin_b   = v;
    @(posedge clk);
    #1 start_b = 1'b0;
    lat = 0;
    while (!done_b && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    r = bcd_b;
    o = ovf_b;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_a); end
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done_a); end
    checks++; if (bcd_a !== 16'h0000) begin errors++; $display("FAIL reset_bcd got %h want 0000", bcd_a); end
    checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf_a); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [15:0] r;
    logic o;
    int lat, bc;
    int vals[4] = '{0, 1023, 9, 10};
    foreach (vals[i]) begin
      run_a(10'(vals[i]), r, o, lat, bc);
      checks++; if (r !== ref_bcd(vals[i])) begin errors++; $display("FAIL basic_bcd in=%0d got %h want %h", vals[i], r, ref_bcd(vals[i])); end
      checks++; if (o !== 1'b0) begin errors++; $display("FAIL basic_ovf in=%0d got %b want 0", vals[i], o); end
      checks++; if (lat != 10) begin errors++; $display("FAIL basic_latency in=%0d got %0d want 10", vals[i], lat); end
      checks++; if (bc != 10) begin errors++; $display("FAIL basic_busy_cycles in=%0d got %0d want 10", vals[i], bc); end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    // start 999, then a stray start with 5 at edge k+3 while busy
    @(negedge clk);
    start_a = 1'b1;
    bin_a   = 10'd999;
    @(posedge clk);
    #1 start_a = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    start_a = 1'b1;
    bin_a   = 10'd5;
    @(posedge clk);
    #1 start_a = 1'b0;
    lat = 3;
    while (!done_a && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++; if (bcd_a !== 16'h0999) begin errors++; $display("FAIL ignore_bcd got %h want 0999", bcd_a); end
    checks++; if (lat != 10) begin errors++; $display("FAIL ignore_latency got %0d want 10", lat); end
    // start during the done cycle
    start_a = 1'b1;
    bin_a   = 10'd5;
    @(posedge clk);
    #1 start_a = 1'b0;
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL b2b_accept busy got %b want 1", busy_a); end
    checks++; if (bcd_a !== 16'h0999) begin errors++; $display("FAIL b2b_hold got %h want 0999", bcd_a); end
    lat = 0;
    while (!done_a && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++; if (bcd_a !== 16'h0005) begin errors++; $display("FAIL b2b_bcd got %h want 0005", bcd_a); end
    checks++; if (lat != 10) begin errors++; $display("FAIL b2b_latency got %0d want 10", lat); end
  endtask

  task automatic test_reset_mid();
    int seen;
    @(negedge clk);
    start_a = 1'b1;
    bin_a   = 10'd512;
    @(posedge clk);
    #1 start_a = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy_a); end
    checks++; if (bcd_a !== 16'h0000) begin errors++; $display("FAIL midrst_bcd got %h want 0000", bcd_a); end
    checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL midrst_ovf got %b want 0", ovf_a); end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (done_a) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL midrst_no_done got %0d pulses want 0", seen); end
  endtask

  task automatic test_wide();
    logic [15:0] r;
    logic o;
    int lat, v;
    int vals[6] = '{12345, 9999, 10000, 16383, 0, 0};
    vals[4] = int'($urandom_range(0, 16383));
    vals[5] = int'($urandom_range(0, 16383));
    foreach (vals[i]) begin
      v = vals[i];
      run_b(14'(v), r, o, lat);
      checks++; if (r !== ref_bcd(v)) begin errors++; $display("FAIL wide_bcd in=%0d got %h want %h", v, r, ref_bcd(v)); end
      checks++; if (o !== (v >= 10000)) begin errors++; $display("FAIL wide_ovf in=%0d got %b want %b", v, o, (v >= 10000)); end
      checks++; if (lat != 14) begin errors++; $display("FAIL wide_latency in=%0d got %0d want 14", v, lat); end
    end
  endtask

  task automatic test_sweep();
    int order[1024];
    int j, tmp, lat, bc, bad_digit;
    logic [15:0] r;
    logic o;
    for (int i = 0; i < 1024; i++) order[i] = i;
    for (int i = 1023; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      tmp = order[i]; order[i] = order[j]; order[j] = tmp;
    end
    for (int i = 0; i < 1024; i++) begin
      run_a(10'(order[i]), r, o, lat, bc);
      checks++; if (r !== ref_bcd(order[i])) begin errors++; $display("FAIL sweep_bcd in=%0d got %h want %h", order[i], r, ref_bcd(order[i])); end
      checks++; if (o !== 1'b0) begin errors++; $display("FAIL sweep_ovf in=%0d got %b want 0", order[i], o); end
      checks++; if (lat != 10) begin errors++; $display("FAIL sweep_latency in=%0d got %0d want 10", order[i], lat); end
      bad_digit = 0;
      for (int d = 0; d < 4; d++) if (r[4*d +: 4] > 4'd9) bad_digit++;
      checks++; if (bad_digit != 0) begin errors++; $display("FAIL sweep_digit_range in=%0d got %h want all digits <=9", order[i], r); end
      @(posedge clk);
      #1;
      checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL sweep_done_width in=%0d got %b want 0", order[i], done_a); end
      checks++; if (bcd_a !== r) begin errors++; $display("FAIL sweep_hold in=%0d got %h want %h", order[i], bcd_a, r); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_reset_mid();
    test_wide();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
